sic_seq_detector: RTL and testbench
===================================

// Module: sic_seq_detector
// PURPOSE
//  Clocked, parametrised single-input-change (SIC) sequence detector for a W-bit input vector.
//  Tracks input changes against a programmable DEPTH-entry vector sequence.
//  Asserts z while the final vector of a completed sequence is held.
//  Flags multiple-input-change (MIC) violations and enters a FAULT state; counts matches.
// PARAMETERS
//  W        2          input vector width (>=1)
//  DEPTH    3          sequence length in vectors (>=2)
//  PATTERN  6'b111000  reset pattern, DEPTH*W bits, element k at [k*W +: W] (default 00,10,11)
//  CNT_W    8          hit counter width
// PORTS
//  clk      in   1                 single clock, all state on rising edge
//  rst      in   1                 asynchronous, active-low reset
//  x        in   W                 input vector, sampled every clk
//  cfg_we   in   1                 pattern write strobe
//  cfg_idx  in   $clog2(DEPTH)     element index to write (>=DEPTH ignored)
//  cfg_vec  in   W                 element value
//  z        out  1                 sequence-complete level
//  mic_err  out  1                 1-cycle pulse per MIC violation
//  fault    out  1                 high while in FAULT
//  hit_cnt  out  CNT_W             saturating match count
//  state_o  out  2                 IDLE=0, TRACK=1, MATCH=2, FAULT=3
// BEHAVIOUR
//  Reset (rst=0, async): pat regs <= PATTERN; x_q <= pat[0]; state TRACK, idx=1;
//   z=0, mic_err=0, fault=0, hit_cnt=0.
//  Change detect: chg = x ^ x_q. nchg = popcount(chg). x_q <= x every cycle.
//   event = (nchg==1); mic = (nchg>=2). No change means no state action.
//  Latency: outputs registered; z/mic_err/fault valid 1 clk after the edge sampling the new x.
//  Priority per cycle: mic > cfg_we > event.
//   mic: mic_err=1 for one cycle; state FAULT; z=0; idx=0.
//    Fires in any state, including FAULT and a cfg_we cycle.
//   cfg_we (no mic): pat[cfg_idx] <= cfg_vec; state IDLE; z=0; hit_cnt=0; fault clears.
//  Event transitions (new = x):
//   IDLE : new==pat[0] -> TRACK idx=1; else stay.
//   TRACK: new==pat[idx] -> idx==DEPTH-1 ? MATCH (z=1, hit_cnt+1 sat) : idx+1;
//          else new==pat[0] -> TRACK idx=1; else IDLE.
//   MATCH: z=1 until next event; then z=0 and apply IDLE rule.
//   FAULT: fault=1; only exit is an event with new==pat[0] -> TRACK idx=1, fault=0.
//  Restart is non-overlapping: no partial-suffix reuse beyond the pat[0] check.
//  hit_cnt saturates at 2^CNT_W-1. It clears only on reset or cfg_we.
//  If pat[k]==pat[k-1], element k is unreachable; no special handling.
//  Reset mid-sequence returns to TRACK idx=1 immediately (async), regardless of x.
// STRUCTURE
//  sic_pkg: state enum (IDLE/TRACK/MATCH/FAULT), state width constant.
//  Sub-module sic_chg_detect #(W): holds x_q, outputs event, mic, new vector.
//   x_q reset value comes from a port driven with pat[0].
//  Top level: pattern register file, FSM with idx counter, hit counter.
// TESTING (W=2, DEPTH=3, default pattern 00,10,11, x=00 at reset)
//  1 release reset, x 00->10->11 -> z=1 one clk after 11 sampled, hit_cnt=1, state MATCH.
//  2 from MATCH, x 11->01 -> z=0 next clk, state IDLE; x 01->11 -> z stays 0.
//  3 x 00->01->11 -> z=0 throughout, state IDLE after 01.
//  4 x 00->11 (two bits) -> mic_err pulse 1 clk, fault=1, z=0;
//    then 11->10->00 -> fault=0, TRACK; then 10,11 -> z=1.
//  5 cfg_we idx1=01 -> state IDLE, hit_cnt=0; then x 00->01->00->01->11 -> z=1 after 11.
//  6 CNT_W=2: four matches -> hit_cnt=3 (saturated);
//    rst low mid-TRACK -> z=0, hit_cnt=0, state TRACK idx1.

Source files
------------

// File: rtl/sic_pkg.sv
// Shared types for the single-input-change sequence detector.
// State encoding is visible on state_o, so the values are fixed.
package sic_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_MATCH = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/sic_chg_detect.sv
// Input change detector: keeps the previous input vector and reports whether
// the current one differs from it in exactly one bit (event) or in several (mic).
module sic_chg_detect #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_rst_val,
  output logic         o_evt,
  output logic         o_mic,
  output logic [W-1:0] o_new
);

  logic [W-1:0] r_x_q;
  logic [W-1:0] w_chg;
  int           w_nchg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_x_q <= i_rst_val;
    else      r_x_q <= i_x;
  end

  assign w_chg  = i_x ^ r_x_q;
  assign w_nchg = $countones(w_chg);
  assign o_evt  = (w_nchg == 1);
  assign o_mic  = (w_nchg > 1);
  assign o_new  = i_x;

endmodule

// File: rtl/sic_seq_detector.sv
// SIC sequence detector: tracks single-bit input changes against a programmable
// DEPTH-entry vector pattern, flags multi-bit changes and counts completed matches.
module sic_seq_detector
  import sic_pkg::*;
#(
  parameter int                   W       = 2,
  parameter int                   DEPTH   = 3,
  parameter logic [DEPTH*W-1:0]   PATTERN = 6'b111000,
  parameter int                   CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             x,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [W-1:0]             cfg_vec,
  output logic                     z,
  output logic                     mic_err,
  output logic                     fault,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [STATE_W-1:0]       state_o
);

  localparam int           IW   = $clog2(DEPTH);
  localparam logic [W-1:0] PAT0 = PATTERN[W-1:0];

  logic [W-1:0]     r_pat [DEPTH];
  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_hit, w_hit_nxt;
  logic             r_mic_err;

  logic             w_evt;
  logic             w_mic;
  logic [W-1:0]     w_new;
  logic [W-1:0]     w_pat_cur;

  // While reset is asserted pat[0] holds its reset value, so the change
  // detector's reset value is that constant.
  sic_chg_detect #(.W(W)) u_chg_detect (
    .clk       (clk),
    .rst       (rst),
    .i_x       (x),
    .i_rst_val (PAT0),
    .o_evt     (w_evt),
    .o_mic     (w_mic),
    .o_new     (w_new)
  );

  // NOTE: the pattern registers are reset because PATTERN is the power-up
  // sequence; an ordinary data memory would be left without reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_pat[i] <= PATTERN[i*W +: W];
    end else if (cfg_we && !w_mic) begin
      for (int i = 0; i < DEPTH; i++)
        if (cfg_idx == IW'(i)) r_pat[i] <= cfg_vec;
    end
  end

  assign w_pat_cur = r_pat[r_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_TRACK;
      r_idx     <= IW'(1);
      r_hit     <= '0;
      r_mic_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; blocking here would create order-dependent races.
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_hit     <= w_hit_nxt;
      r_mic_err <= w_mic;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_hit_nxt   = r_hit;

    if (w_mic) begin
      w_state_nxt = ST_FAULT;
      w_idx_nxt   = '0;
    end else if (cfg_we) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_hit_nxt   = '0;
    end else if (w_evt) begin
      unique case (r_state)
        ST_TRACK: begin
          if (w_new == w_pat_cur) begin
            if (r_idx == IW'(DEPTH-1)) begin
              w_state_nxt = ST_MATCH;
              w_idx_nxt   = '0;
              if (r_hit != '1) w_hit_nxt = r_hit + 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else if (w_new == r_pat[0]) begin
            w_idx_nxt = IW'(1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
          end
        end
        ST_FAULT: begin
          if (w_new == r_pat[0]) begin
            w_state_nxt = ST_TRACK;
            w_idx_nxt   = IW'(1);
          end
        end
        default: begin
          // IDLE and MATCH share the restart rule; only pat[0] is reused.
          if (w_new == r_pat[0]) begin
            w_state_nxt = ST_TRACK;
            w_idx_nxt   = IW'(1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
          end
        end
      endcase
    end
  end

  assign z       = (r_state == ST_MATCH);
  assign fault   = (r_state == ST_FAULT);
  assign mic_err = r_mic_err;
  assign hit_cnt = r_hit;
  assign state_o = r_state;

endmodule

// File: tb/tb_sic_seq_detector.sv
// Self-checking bench: driver feeds directed and random vectors into a
// behavioural model and a scoreboard queue; a monitor compares after each edge.
module tb_sic_seq_detector;

  localparam int                 W       = 2;
  localparam int                 DEPTH   = 3;
  localparam int                 CNT_W   = 2;
  localparam int                 IW      = 2;
  localparam logic [DEPTH*W-1:0] PATTERN = 6'b111000;
  localparam int                 HIT_MAX = (1 << CNT_W) - 1;

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic [W-1:0]     x       = '0;
  logic             cfg_we  = 1'b0;
  logic [IW-1:0]    cfg_idx = '0;
  logic [W-1:0]     cfg_vec = '0;
  logic             z;
  logic             mic_err;
  logic             fault;
  logic [CNT_W-1:0] hit_cnt;
  logic [1:0]       state_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sic_seq_detector #(
    .W(W), .DEPTH(DEPTH), .PATTERN(PATTERN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_vec(cfg_vec), .z(z), .mic_err(mic_err), .fault(fault),
    .hit_cnt(hit_cnt), .state_o(state_o)
  );

  typedef struct {
    int z;
    int mic;
    int fault;
    int hit;
    int st;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: progress = number of pattern elements matched so far
  // (0 idle, DEPTH complete), plus a fault flag.
  int m_pat [DEPTH];
  int m_xq;
  int m_pos;
  bit m_fault;
  bit m_mic;
  int m_hits;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int popcount(input int v);
    int c = 0;
    for (int i = 0; i < W; i++) c += (v >> i) & 1;
    return c;
  endfunction

  function automatic void model_reset();
    logic [DEPTH*W-1:0] p;
    p = PATTERN;
    for (int k = 0; k < DEPTH; k++) m_pat[k] = int'(p[k*W +: W]);
    m_xq    = m_pat[0];
    m_pos   = 1;
    m_fault = 1'b0;
    m_mic   = 1'b0;
    m_hits  = 0;
  endfunction

  function automatic void model_step(input bit rn, input int nx, input bit we,
                                     input int idx, input int vec);
    int n;
    if (!rn) begin
      model_reset();
      return;
    end
    n     = popcount(nx ^ m_xq);
    m_xq  = nx;
    m_mic = 1'b0;
    if (n >= 2) begin
      m_mic   = 1'b1;
      m_fault = 1'b1;
      m_pos   = 0;
    end else if (we) begin
      if (idx < DEPTH) m_pat[idx] = vec;
      m_pos   = 0;
      m_fault = 1'b0;
      m_hits  = 0;
    end else if (n == 1) begin
      if (m_fault) begin
        if (nx == m_pat[0]) begin
          m_fault = 1'b0;
          m_pos   = 1;
        end
      end else if (m_pos >= 1 && m_pos < DEPTH && nx == m_pat[m_pos]) begin
        m_pos++;
        if (m_pos == DEPTH && m_hits < HIT_MAX) m_hits++;
      end else begin
        m_pos = (nx == m_pat[0]) ? 1 : 0;
      end
    end
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.z     = (!m_fault && m_pos == DEPTH) ? 1 : 0;
    e.mic   = m_mic ? 1 : 0;
    e.fault = m_fault ? 1 : 0;
    e.hit   = m_hits;
    e.st    = m_fault ? 3 : (m_pos == DEPTH) ? 2 : (m_pos == 0) ? 0 : 1;
    return e;
  endfunction

  task automatic cycle(input logic r, input logic [W-1:0] nx, input logic we,
                       input logic [IW-1:0] idx, input logic [W-1:0] vec);
    @(negedge clk);
    rst     = r;
    x       = nx;
    cfg_we  = we;
    cfg_idx = idx;
    cfg_vec = vec;
    model_step(r, int'(nx), we, int'(idx), int'(vec));
    exp_q.push_back(model_exp());
  endtask

  task automatic step(input logic [W-1:0] nx);
    cycle(1'b1, nx, 1'b0, '0, '0);
  endtask

  task automatic peek(input string name, input int ez, input int emic,
                      input int efault, input int est, input int ehit);
    @(posedge clk);
    #2;
    check({name, " z"},       int'(z),       ez);
    check({name, " mic_err"}, int'(mic_err), emic);
    check({name, " fault"},   int'(fault),   efault);
    check({name, " state"},   int'(state_o), est);
    check({name, " hit_cnt"}, int'(hit_cnt), ehit);
  endtask

  // Monitor: every output sample after an edge is matched to one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb z",       int'(z),       e.z);
        check("sb mic_err", int'(mic_err), e.mic);
        check("sb fault",   int'(fault),   e.fault);
        check("sb hit_cnt", int'(hit_cnt), e.hit);
        check("sb state",   int'(state_o), e.st);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] one;
    logic [W-1:0] nx;
    int           r;
    one = 1;

    // Asynchronous reset assertion with no clock edge involved.
    model_reset();
    #2 rst = 1'b0;
    #1;
    check("rst state",   int'(state_o), 1);
    check("rst z",       int'(z),       0);
    check("rst fault",   int'(fault),   0);
    check("rst mic_err", int'(mic_err), 0);
    check("rst hit_cnt", int'(hit_cnt), 0);
    cycle(1'b0, 2'b00, 1'b0, '0, '0);
    cycle(1'b0, 2'b00, 1'b0, '0, '0);

    // 1: 00 -> 10 -> 11 completes the default sequence.
    cycle(1'b1, 2'b00, 1'b0, '0, '0);
    step(2'b10);
    step(2'b11);
    peek("t1 match", 1, 0, 0, 2, 1);

    // 2: leave MATCH to IDLE; 11 from IDLE does not start a sequence.
    step(2'b01);
    peek("t2 idle", 0, 0, 0, 0, 1);
    step(2'b11);
    peek("t2 stay", 0, 0, 0, 0, 1);

    // 3: wrong second element drops to IDLE.
    step(2'b01);
    step(2'b00);
    step(2'b01);
    peek("t3 idle", 0, 0, 0, 0, 1);
    step(2'b11);
    peek("t3 stay", 0, 0, 0, 0, 1);

    // 4: two-bit change faults; only pat[0] exits the fault.
    step(2'b10);
    step(2'b00);
    step(2'b11);
    peek("t4 mic", 0, 1, 1, 3, 1);
    step(2'b10);
    peek("t4 hold", 0, 0, 1, 3, 1);
    step(2'b00);
    peek("t4 exit", 0, 0, 0, 1, 1);
    step(2'b10);
    step(2'b11);
    peek("t4 match", 1, 0, 0, 2, 2);

    // 5: reprogram element 1 to 01, then restart within the sequence.
    cycle(1'b1, 2'b11, 1'b1, 2'd1, 2'b01);
    peek("t5 cfg", 0, 0, 0, 0, 0);
    step(2'b01);
    step(2'b00);
    step(2'b01);
    step(2'b00);
    step(2'b01);
    step(2'b11);
    peek("t5 match", 1, 0, 0, 2, 1);

    // 6: counter saturation, then async reset in the middle of tracking.
    repeat (4) begin
      step(2'b01);
      step(2'b00);
      step(2'b01);
      step(2'b11);
    end
    peek("t6 sat", 1, 0, 0, 2, HIT_MAX);
    step(2'b01);
    step(2'b00);
    step(2'b01);
    cycle(1'b0, 2'b01, 1'b0, '0, '0);
    #1;
    check("t6 rst state",   int'(state_o), 1);
    check("t6 rst z",       int'(z),       0);
    check("t6 rst hit_cnt", int'(hit_cnt), 0);
    check("t6 rst fault",   int'(fault),   0);

    // Random phase: mostly single-bit walks, with mic, cfg and reset mixed in.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        cycle(1'b1, x ^ 2'b11, 1'b0, '0, '0);
      end else if (r < 9) begin
        nx = x ^ W'($urandom);
        cycle(1'b1, nx, 1'b1, IW'($urandom_range(0, 3)), W'($urandom));
      end else if (r < 11) begin
        cycle(1'b0, W'($urandom), 1'b0, '0, '0);
      end else if (r < 18) begin
        step(x);
      end else begin
        nx = one << $urandom_range(0, W - 1);
        step(x ^ nx);
      end
    end

    @(posedge clk);
    #3;
    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
